booth_ctrl: RTL and testbench

Control sequencer for the radix-2 Booth multiplier datapath in the ALU-64 core. It generates the one-hot control strobes c0..c6 that drive the operand registers and the adder: c0 loads reg_M, c1 loads Q and clears A, c2/c3 add or subtract M, c4 shifts A:Q:Q-1, and c5/c6 drive the result onto outbus. It sits directly upstream of reg_M and the A/Q registers. It sequences w iterations from a start pulse and signals completion with a single-cycle done.

---
 rtl/booth_ctrl.sv | 124 ++++++++++++
 tb/tb_booth_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier control sequencer.
// Issues one-hot datapath strobes c0..c6 for a w-iteration multiply.
module booth_ctrl #(
    parameter int w  = 16,
    parameter int CW = $clog2(w)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          q0,
    input  logic          q_1,
    output logic          c0,
    output logic          c1,
    output logic          c2,
    output logic          c3,
    output logic          c4,
    output logic          c5,
    output logic          c6,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_M = 4'd1,
        LOAD_Q = 4'd2,
        TEST   = 4'd3,
        ADD    = 4'd4,
        SUB    = 4'd5,
        SHIFT  = 4'd6,
        OUT_A  = 4'd7,
        OUT_Q  = 4'd8,
        DONE   = 4'd9
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(w - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt_nxt;

    // State and iteration counter registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic and Moore strobe decode from the registered state.
    always_comb begin
        state_nxt = IDLE;
        cnt_nxt   = cnt;
        c0        = 1'b0;
        c1        = 1'b0;
        c2        = 1'b0;
        c3        = 1'b0;
        c4        = 1'b0;
        c5        = 1'b0;
        c6        = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy      = 1'b0;
                state_nxt = start ? LOAD_M : IDLE;
            end
            LOAD_M: begin
                c0        = 1'b1;
                state_nxt = LOAD_Q;
            end
            LOAD_Q: begin
                c1        = 1'b1;
                cnt_nxt   = '0;
                state_nxt = TEST;
            end
            TEST: begin
                unique case ({q0, q_1})
                    2'b10:   state_nxt = SUB;
                    2'b01:   state_nxt = ADD;
                    default: state_nxt = SHIFT;
                endcase
            end
            ADD: begin
                c2        = 1'b1;
                state_nxt = SHIFT;
            end
            SUB: begin
                c3        = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                c4 = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = OUT_A;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                    state_nxt = TEST;
                end
            end
            OUT_A: begin
                c5        = 1'b1;
                state_nxt = OUT_Q;
            end
            OUT_Q: begin
                c6        = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Self-checking bench for booth_ctrl.
// Per-cycle strobe trace is built from the iteration rules of the multiply.
module tb_booth_ctrl;

    localparam int W  = 16;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          q0;
    logic          q_1;
    logic          c0, c1, c2, c3, c4, c5, c6;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;

    int n_vec  = 0;
    int n_fail = 0;
    int m_cnt  = 0;

    typedef struct {
        logic [6:0]    c;
        logic          dn;
        logic          bz;
        logic [CW-1:0] ct;
        logic [1:0]    q;
    } slot_t;

    typedef struct {
        string       name;
        logic [31:0] qpat;
        int          cyc;
        int          n2;
        int          n3;
    } vec_t;

    booth_ctrl #(.w(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .q0    (q0),
        .q_1   (q_1),
        .c0    (c0),
        .c1    (c1),
        .c2    (c2),
        .c3    (c3),
        .c4    (c4),
        .c5    (c5),
        .c6    (c6),
        .busy  (busy),
        .done  (done),
        .cnt   (cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] strobes();
        return {c6, c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic chk(input string nm, input logic [6:0] ec,
                       input logic eb, input logic ed,
                       input logic [CW-1:0] ect);
        logic [6:0] a;
        a = strobes();
        n_vec++;
        if ({a, busy, done, cnt} !== {ec, eb, ed, ect}) begin
            n_fail++;
            $display("FAIL %s: got c=%b busy=%b done=%b cnt=%0d, want c=%b busy=%b done=%b cnt=%0d",
                     nm, a, busy, done, cnt, ec, eb, ed, ect);
        end
        n_vec++;
        if ($countones(a) > 1) begin
            n_fail++;
            $display("FAIL %s onehot: got c=%b, want at most one bit", nm, a);
        end
    endtask

    task automatic cmp_int(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // Entered at a negedge of an IDLE cycle. b2b keeps start high throughout;
    // abort_at >= 0 asserts rst right after that trace slot is checked.
    task automatic run_op(input string nm, input logic [31:0] qpat,
                          input int ecyc, input int en2, input int en3,
                          input bit b2b, input int abort_at);
        slot_t   tr[$];
        slot_t   s;
        logic [1:0] pr;
        int      n_done;
        int      a2, a3, a4;
        s = '{c: 7'b0000001, dn: 1'b0, bz: 1'b1, ct: CW'(m_cnt), q: 2'($urandom)};
        tr.push_back(s);
        s.c = 7'b0000010; s.q = 2'($urandom);
        tr.push_back(s);
        for (int i = 0; i < W; i++) begin
            pr = qpat[2*i +: 2];
            s = '{c: 7'b0, dn: 1'b0, bz: 1'b1, ct: CW'(i), q: pr};
            tr.push_back(s);
            s.q = 2'($urandom);
            if (pr == 2'b10) begin
                s.c = 7'b0001000;
                tr.push_back(s);
            end else if (pr == 2'b01) begin
                s.c = 7'b0000100;
                tr.push_back(s);
            end
            s.c = 7'b0010000;
            tr.push_back(s);
        end
        s = '{c: 7'b0100000, dn: 1'b0, bz: 1'b1, ct: CW'(W - 1), q: 2'($urandom)};
        tr.push_back(s);
        s.c = 7'b1000000;
        tr.push_back(s);
        s.c = 7'b0; s.dn = 1'b1;
        tr.push_back(s);

        start  = 1'b1;
        n_done = -1;
        a2 = 0; a3 = 0; a4 = 0;
        for (int k = 0; k < tr.size(); k++) begin
            @(negedge clk);
            chk(nm, tr[k].c, tr[k].bz, tr[k].dn, tr[k].ct);
            if (done && n_done < 0) n_done = k + 1;
            a2 += int'(c2);
            a3 += int'(c3);
            a4 += int'(c4);
            {q0, q_1} = tr[k].q;
            if (b2b) start = 1'b1;
            else if (k == tr.size() - 1) start = 1'b0;
            else start = 1'($urandom);
            if (k == abort_at) begin
                rst   = 1'b1;
                start = 1'b1;
                @(negedge clk);
                chk({nm, "_rst"}, 7'b0, 1'b0, 1'b0, '0);
                rst   = 1'b0;
                start = 1'b0;
                m_cnt = 0;
                return;
            end
        end
        m_cnt = W - 1;
        @(negedge clk);
        chk({nm, "_idle"}, 7'b0, 1'b0, 1'b0, CW'(m_cnt));
        cmp_int({nm, "_done_cyc"}, n_done, ecyc);
        cmp_int({nm, "_n_add"}, a2, en2);
        cmp_int({nm, "_n_sub"}, a3, en3);
        cmp_int({nm, "_n_shift"}, a4, W);
    endtask

    initial begin
        vec_t tbl[6];
        logic [31:0] qp;
        logic [1:0]  pr;
        int n2, n3, cut;

        tbl[0] = '{"all_shift", 32'h0000_0000, 37, 0,  0};
        tbl[1] = '{"decode",    32'hFFFF_FFF6, 39, 1,  1};
        tbl[2] = '{"worst",     32'h6666_6666, 53, 8,  8};
        tbl[3] = '{"all_11",    32'hFFFF_FFFF, 37, 0,  0};
        tbl[4] = '{"all_01",    32'h5555_5555, 53, 16, 0};
        tbl[5] = '{"all_10",    32'hAAAA_AAAA, 53, 0,  16};

        rst   = 1'b1;
        start = 1'b1;
        q0    = 1'b1;
        q_1   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", 7'b0, 1'b0, 1'b0, '0);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("reset_release", 7'b0, 1'b0, 1'b0, '0);
        end

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].name, tbl[i].qpat, tbl[i].cyc,
                   tbl[i].n2, tbl[i].n3, 1'b0, -1);

        // Iteration 7 takes the ADD path; reset lands on that ADD slot:
        // slots LOAD_M, LOAD_Q, 7 x (TEST,SHIFT), TEST -> ADD is index 17.
        cut = 2 + 7 * 2 + 1;
        run_op("mid_rst", 32'h0000_4000, 0, 0, 0, 1'b0, cut);
        run_op("after_rst", 32'h0000_0000, 37, 0, 0, 1'b0, -1);

        run_op("b2b_a", 32'h0000_0000, 37, 0, 0, 1'b1, -1);
        run_op("b2b_b", 32'h6666_6666, 53, 8, 8, 1'b1, -1);
        run_op("b2b_c", 32'hFFFF_FFF6, 39, 1, 1, 1'b0, -1);

        for (int r = 0; r < 20; r++) begin
            qp = $urandom;
            n2 = 0;
            n3 = 0;
            for (int i = 0; i < W; i++) begin
                pr = qp[2*i +: 2];
                if (pr == 2'b01) n2++;
                if (pr == 2'b10) n3++;
            end
            run_op("rand", qp, 2 * W + 5 + n2 + n3, n2, n3, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
